// File: rtl/adc_decimator_if.sv
// Upstream sample/control signals and the downstream result handshake.
// The master drives samples and accepts results; the slave is the decimator.
interface adc_decimator_if #(
  parameter int DEC_LOG2   = 4,
  parameter int FIFO_DEPTH = 4
) ();
  localparam int W  = 3 + DEC_LOG2;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]    code;
  logic          code_valid;
  logic          en;
  logic          restart;
  logic          clr_ovf;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [LW-1:0] level;
  logic          overflow;

  modport master (
    output code, code_valid, en, restart, clr_ovf, dout_ready,
    input  dout, dout_valid, level, overflow
  );

  modport slave (
    input  code, code_valid, en, restart, clr_ovf, dout_ready,
    output dout, dout_valid, level, overflow
  );
endinterface

// File: rtl/adc_decimator.sv
// Sums 2^DEC_LOG2 consecutive encoder codes into one word and queues the
// words in a small FIFO drained over valid/ready. Drops raise a sticky flag.
module adc_decimator #(
  parameter int DEC_LOG2   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  adc_decimator_if.slave    bus
);
  localparam int W  = 3 + DEC_LOG2;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DEC_LOG2-1:0] CNT_LAST = {DEC_LOG2{1'b1}};

  logic [W-1:0]        acc;
  logic [DEC_LOG2-1:0] cnt;
  logic [W-1:0]        sum;
  logic                sample, last, push, pop, full, wr_ok, drop;

  logic [FIFO_DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level;
  logic                ovf;
  logic                dvld;

  // Sample qualification and FIFO push/pop decisions.
  always_comb begin
    sample = bus.en && bus.code_valid && !bus.restart;
    last   = (cnt == CNT_LAST);
    // 7*N fits exactly in W bits, so no saturation is needed
    sum    = acc + {{DEC_LOG2{1'b0}}, bus.code};
    push   = sample && last;
    dvld   = (level != '0);
    pop    = dvld && bus.dout_ready;
    full   = (level == LW'(FIFO_DEPTH));
    // when full, a same-cycle pop frees the slot the push lands in
    wr_ok  = push && (!full || pop);
    drop   = push && full && !pop;
  end

  // Accumulator and window counter; restart beats sampling and discards the code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (bus.restart) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample) begin
      acc <= last ? '0 : sum;
      cnt <= cnt + 1'b1;
    end
  end

  // FIFO storage and pointers; full+pop writes the slot being vacated, so the
  // new entry lands at the tail of the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= sum;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy tracks accepted pushes against pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                level <= '0;
    else if (wr_ok && !pop) level <= level + 1'b1;
    else if (!wr_ok && pop) level <= level - 1'b1;
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ovf <= 1'b0;
    else if (drop)        ovf <= 1'b1;
    else if (bus.clr_ovf) ovf <= 1'b0;
  end

  // dout reads as zero whenever the queue is empty.
  always_comb begin
    bus.dout       = dvld ? mem[rd_ptr] : '0;
    bus.dout_valid = dvld;
    bus.level      = level;
    bus.overflow   = ovf;
  end
endmodule

// File: tb/tb_adc_decimator.sv
// Directed bench: one DUT at N=4 for windowing/restart/reset, one at N=2 for
// backpressure, overflow and full-with-pop ordering.
module tb_adc_decimator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   nchk = 0;

  always #5 clk = ~clk;

  adc_decimator_if #(.DEC_LOG2(2), .FIFO_DEPTH(4)) ifa ();
  adc_decimator_if #(.DEC_LOG2(1), .FIFO_DEPTH(4)) ifb ();

  adc_decimator #(.DEC_LOG2(2), .FIFO_DEPTH(4)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  adc_decimator #(.DEC_LOG2(1), .FIFO_DEPTH(4)) u_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one cycle on DUT A
  task automatic sa(input int c, input bit cv, input bit e, input bit rs);
    ifa.code = 3'(c); ifa.code_valid = cv; ifa.en = e; ifa.restart = rs;
    tick();
  endtask

  // one cycle on DUT B (always enabled)
  task automatic sb(input int c, input bit cv);
    ifb.code = 3'(c); ifb.code_valid = cv;
    tick();
  endtask

  initial begin
    ifa.code = '0; ifa.code_valid = 0; ifa.en = 1; ifa.restart = 0;
    ifa.clr_ovf = 0; ifa.dout_ready = 1;
    ifb.code = '0; ifb.code_valid = 0; ifb.en = 1; ifb.restart = 0;
    ifb.clr_ovf = 0; ifb.dout_ready = 0;
    #12;
    chk("rst_a_valid", int'(ifa.dout_valid), 0);
    chk("rst_a_level", int'(ifa.level), 0);
    chk("rst_a_dout",  int'(ifa.dout), 0);
    chk("rst_a_ovf",   int'(ifa.overflow), 0);
    chk("rst_b_valid", int'(ifb.dout_valid), 0);
    rst = 1'b0;
    tick();

    // constant 3 x4 -> 12, visible one cycle, then popped
    for (int i = 0; i < 3; i++) sa(3, 1, 1, 0);
    chk("lat_before_n", int'(ifa.dout_valid), 0);
    sa(3, 1, 1, 0);
    chk("c3_valid", int'(ifa.dout_valid), 1);
    chk("c3_dout",  int'(ifa.dout), 12);
    chk("c3_level", int'(ifa.level), 1);
    sa(0, 0, 1, 0);
    chk("c3_popped", int'(ifa.dout_valid), 0);
    chk("c3_lvl0",   int'(ifa.level), 0);

    // max code -> 28, no wrap
    for (int i = 0; i < 4; i++) sa(7, 1, 1, 0);
    chk("c7_dout", int'(ifa.dout), 28);
    sa(0, 0, 1, 0);

    // gating: 5,5, three frozen cycles with 7 present, 1,1 -> 12
    sa(5, 1, 1, 0); sa(5, 1, 1, 0);
    for (int i = 0; i < 3; i++) sa(7, 1, 0, 0);
    chk("gate_nopush", int'(ifa.dout_valid), 0);
    sa(1, 1, 1, 0);
    chk("gate_partial", int'(ifa.dout_valid), 0);
    sa(1, 1, 1, 0);
    chk("gate_valid", int'(ifa.dout_valid), 1);
    chk("gate_dout",  int'(ifa.dout), 12);
    sa(0, 0, 1, 0);

    // restart: 6,6,6, restart with valid code, then 2 x4 -> one result of 8
    for (int i = 0; i < 3; i++) sa(6, 1, 1, 0);
    sa(6, 1, 1, 1);
    chk("rs_nopush", int'(ifa.dout_valid), 0);
    for (int i = 0; i < 3; i++) sa(2, 1, 1, 0);
    chk("rs_partial", int'(ifa.dout_valid), 0);
    sa(2, 1, 1, 0);
    chk("rs_dout",  int'(ifa.dout), 8);
    chk("rs_level", int'(ifa.level), 1);
    sa(0, 0, 1, 0);
    chk("rs_single", int'(ifa.dout_valid), 0);

    // backpressure on B: 10 samples of 1 -> 5 results, 4 kept, 1 dropped
    for (int i = 0; i < 10; i++) sb(1, 1);
    chk("bp_level", int'(ifb.level), 4);
    chk("bp_ovf",   int'(ifb.overflow), 1);
    ifb.dout_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_valid", int'(ifb.dout_valid), 1);
      chk("bp_drain_dout",  int'(ifb.dout), 2);
      sb(0, 0);
    end
    chk("bp_empty",     int'(ifb.level), 0);
    chk("bp_ovf_stick", int'(ifb.overflow), 1);
    ifb.clr_ovf = 1; sb(0, 0); ifb.clr_ovf = 0;
    chk("bp_ovf_clr", int'(ifb.overflow), 0);

    // full with simultaneous pop: fill 2,4,6,8 then push 10 while popping
    ifb.dout_ready = 0;
    for (int v = 1; v <= 4; v++) begin
      sb(v, 1); sb(v, 1);
    end
    chk("fp_full", int'(ifb.level), 4);
    sb(5, 1);
    ifb.dout_ready = 1;
    chk("fp_head", int'(ifb.dout), 2);
    sb(5, 1);
    chk("fp_level", int'(ifb.level), 4);
    chk("fp_ovf",   int'(ifb.overflow), 0);
    for (int v = 2; v <= 5; v++) begin
      chk("fp_order", int'(ifb.dout), 2 * v);
      sb(0, 0);
    end
    chk("fp_empty", int'(ifb.level), 0);

    // async reset with level=3 and cnt=2 on A
    ifa.dout_ready = 0;
    for (int i = 0; i < 14; i++) sa(1, 1, 1, 0);
    chk("ar_level_pre", int'(ifa.level), 3);
    chk("ar_dout_pre",  int'(ifa.dout), 4);
    sa(0, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", int'(ifa.dout_valid), 0);
    chk("ar_level", int'(ifa.level), 0);
    chk("ar_dout",  int'(ifa.dout), 0);
    chk("ar_ovf",   int'(ifa.overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    ifa.dout_ready = 1;
    for (int i = 0; i < 3; i++) sa(3, 1, 1, 0);
    chk("ar_fresh_partial", int'(ifa.dout_valid), 0);
    sa(3, 1, 1, 0);
    chk("ar_fresh_dout", int'(ifa.dout), 12);
    sa(0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
